mmd_ratio_sched: RTL and testbench

//  Division-ratio scheduler for the 7-bit multi-modulus divider. Clocked by the divided clock,
//  it accepts a new integer+fractional ratio via valid/ready, slews DIVNUM to the new integer

---
 rtl/mmd_pkg.sv | 23 ++
 rtl/mmd_frac_acc.sv | 51 +++++
 rtl/mmd_ratio_sched.sv | 121 ++++++++++++
 tb/tb_mmd_ratio_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmd_pkg.sv
// Shared types and helpers for the multi-modulus divider ratio scheduler.
package mmd_pkg;

    localparam int DIV_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2,
        LOCK   = 2'd3
    } sched_st_t;

    function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] n,
                                                   input logic [DIV_W-1:0] lo,
                                                   input logic [DIV_W-1:0] hi);
        logic [DIV_W-1:0] r;
        r = n;
        if (n < lo) r = lo;
        else if (n > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/mmd_frac_acc.sv
// First-order fractional accumulator; carry drives the N/N+1 selection.
// MMD_SCHED_DITHER_EN adds a 15-bit LFSR whose LSB is the carry-in.
module mmd_frac_acc #(
    parameter int FW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [FW-1:0] frac,
    output logic          carry
);

    logic [FW-1:0] acc_q, acc_d;
    logic [FW:0]   sum;
    logic          cin;

`ifdef MMD_SCHED_DITHER_EN
    logic [14:0] lfsr_q, lfsr_d;

    // x^15 + x^14 + 1; not reseeded on a new ratio so the dither sequence keeps running
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 15'h1;
        else        lfsr_q <= lfsr_d;
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    assign sum   = {1'b0, acc_q} + {1'b0, frac} + {{FW{1'b0}}, cin};
    assign carry = sum[FW];

    always_comb begin
        acc_d = acc_q;
        if (clr)     acc_d = '0;
        else if (en) acc_d = sum[FW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/mmd_ratio_sched.sv
// Division-ratio scheduler: accepts N+frac, slews DIVNUM in bounded steps, settles,
// then dithers N/N+1 (optional LFSR dither via MMD_SCHED_DITHER_EN in mmd_frac_acc).
//   state  | meaning
//   IDLE   | holding cur_int, ready for a ratio
//   RAMP   | stepping cur_int toward tgt_int by at most STEP_MAX per cycle
//   SETTLE | DIVNUM = tgt_int for SETTLE_CYC cycles
//   LOCK   | DIVNUM = tgt_int + carry, ready for a new ratio
module mmd_ratio_sched
    import mmd_pkg::*;
#(
    parameter int FW         = 16,
    parameter int DIV_MIN    = 4,
    parameter int DIV_MAX    = 127,
    parameter int STEP_MAX   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int RST_DIV    = 32
) (
    input  logic             CKVD,
    input  logic             NARST,
    input  logic             CFG_VLD,
    output logic             CFG_RDY,
    input  logic [DIV_W-1:0] CFG_NINT,
    input  logic [FW-1:0]    CFG_FRAC,
    output logic [DIV_W-1:0] DIVNUM,
    output logic             LOCKED,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [DIV_W-1:0] D_MIN  = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] D_HI   = DIV_W'(DIV_MAX - 1);
    localparam logic [DIV_W-1:0] D_STEP = DIV_W'(STEP_MAX);
    localparam logic [DIV_W-1:0] D_RST  = DIV_W'(RST_DIV);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYC - 1);

    sched_st_t        state_q, state_d;
    logic [DIV_W-1:0] cur_int_q, cur_int_d;
    logic [DIV_W-1:0] tgt_int_q, tgt_int_d;
    logic [FW-1:0]    tgt_frac_q, tgt_frac_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DIV_W-1:0] divnum_q, divnum_d;
    logic [DIV_W-1:0] gap, step, ramp_val;
    logic             accept, acc_carry, up;

    assign CFG_RDY = (state_q == IDLE) || (state_q == LOCK);
    assign LOCKED  = (state_q == LOCK);
    assign BUSY    = (state_q == RAMP) || (state_q == SETTLE);
    assign DIVNUM  = divnum_q;
    assign accept  = CFG_VLD && CFG_RDY;

    assign up       = tgt_int_q > cur_int_q;
    assign gap      = up ? (tgt_int_q - cur_int_q) : (cur_int_q - tgt_int_q);
    assign step     = (gap > D_STEP) ? D_STEP : gap;
    assign ramp_val = up ? (cur_int_q + step) : (cur_int_q - step);

    mmd_frac_acc #(.FW(FW)) u_acc (
        .clk   (CKVD),
        .rst_n (NARST),
        .en    (state_q == LOCK),
        .clr   (accept),
        .frac  (tgt_frac_q),
        .carry (acc_carry)
    );

    always_comb begin
        state_d      = state_q;
        cur_int_d    = cur_int_q;
        tgt_int_d    = tgt_int_q;
        tgt_frac_d   = tgt_frac_q;
        settle_cnt_d = settle_cnt_q;
        divnum_d     = divnum_q;
        case (state_q)
            IDLE: divnum_d = cur_int_q;
            RAMP: begin
                cur_int_d = ramp_val;
                divnum_d  = ramp_val;
                if (ramp_val == tgt_int_q) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                divnum_d = tgt_int_q;
                if (settle_cnt_q == S_LAST) begin
                    state_d      = LOCK;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            LOCK: divnum_d = tgt_int_q + DIV_W'(acc_carry);
            default: state_d = IDLE;
        endcase
        // A new ratio always restarts the ramp from where cur_int currently sits
        if (accept) begin
            state_d    = RAMP;
            tgt_int_d  = clamp_int(CFG_NINT, D_MIN, D_HI);
            tgt_frac_d = CFG_FRAC;
            divnum_d   = cur_int_q;
        end
    end

    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            state_q      <= IDLE;
            cur_int_q    <= D_RST;
            tgt_int_q    <= D_RST;
            tgt_frac_q   <= '0;
            settle_cnt_q <= '0;
            divnum_q     <= D_RST;
        end else begin
            state_q      <= state_d;
            cur_int_q    <= cur_int_d;
            tgt_int_q    <= tgt_int_d;
            tgt_frac_q   <= tgt_frac_d;
            settle_cnt_q <= settle_cnt_d;
            divnum_q     <= divnum_d;
        end
    end

endmodule

// File: tb/tb_mmd_ratio_sched.sv
// Self-checking bench for mmd_ratio_sched: directed scenarios plus random ratios
// against an expectation-queue / closed-form carry model.
module tb_mmd_ratio_sched;

    localparam int FW = 16;

    logic        CKVD = 1'b0;
    logic        NARST = 1'b0;
    logic        CFG_VLD = 1'b0;
    logic        CFG_RDY;
    logic [6:0]  CFG_NINT = '0;
    logic [15:0] CFG_FRAC = '0;
    logic [6:0]  DIVNUM;
    logic        LOCKED, BUSY;

    int checks = 0;
    int errors = 0;

    mmd_ratio_sched dut (
        .CKVD     (CKVD),
        .NARST    (NARST),
        .CFG_VLD  (CFG_VLD),
        .CFG_RDY  (CFG_RDY),
        .CFG_NINT (CFG_NINT),
        .CFG_FRAC (CFG_FRAC),
        .DIVNUM   (DIVNUM),
        .LOCKED   (LOCKED),
        .BUSY     (BUSY)
    );

    always #5 CKVD = ~CKVD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Carries of a first-order accumulator starting from 0: floor differences of k*frac/2^FW
    function automatic int carry_of(input longint k, input longint f);
        return int'((((k + 1) * f) >> FW) - ((k * f) >> FW));
    endfunction

    function automatic int clamp(input int n);
        return (n < 4) ? 4 : ((n > 126) ? 126 : n);
    endfunction

    typedef struct {
        int dn;
        bit busy;
        bit lock;
        bit rdy;
    } exp_t;

    exp_t   q[$];
    exp_t   e = '{32, 1'b0, 1'b0, 1'b1};
    int     m_cur = 32;
    int     m_tgt = 32;
    int     m_frac = 0;
    bit     m_inlock = 1'b0;
    longint m_k = 0;
    bit     m_acc_pulse = 1'b0;

    always @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            q.delete();
            e = '{32, 1'b0, 1'b0, 1'b1};
            m_cur = 32; m_tgt = 32; m_frac = 0; m_inlock = 1'b0; m_k = 0;
            m_acc_pulse = 1'b0;
        end else begin
            m_acc_pulse = 1'b0;
            if (CFG_VLD && e.rdy) begin
                int c;
                m_acc_pulse = 1'b1;
                m_tgt = clamp(int'(CFG_NINT));
                m_frac = int'(CFG_FRAC);
                q.delete();
                q.push_back('{m_cur, 1'b1, 1'b0, 1'b0});
                c = m_cur;
                do begin
                    if (m_tgt > c)      c += (m_tgt - c > 4) ? 4 : (m_tgt - c);
                    else if (c > m_tgt) c -= (c - m_tgt > 4) ? 4 : (c - m_tgt);
                    q.push_back('{c, 1'b1, 1'b0, 1'b0});
                end while (c != m_tgt);
                for (int i = 0; i < 8; i++)
                    q.push_back('{m_tgt, i < 7, i == 7, i == 7});
                m_cur = m_tgt;
                m_inlock = 1'b0;
                m_k = 0;
                e = q.pop_front();
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (q.size() == 0) m_inlock = 1'b1;
            end else if (m_inlock) begin
                e.dn = m_tgt + carry_of(m_k, longint'(m_frac));
                m_k++;
            end
        end
    end

    always @(negedge CKVD) begin
        if (NARST) begin
            chk("divnum", 32'(DIVNUM), 32'(e.dn));
            chk("busy", 32'(BUSY), 32'(e.busy));
            chk("locked", 32'(LOCKED), 32'(e.lock));
            chk("cfg_rdy", 32'(CFG_RDY), 32'(e.rdy));
            chk("divnum_min", 32'(DIVNUM >= 7'd4), 32'd1);
        end
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(posedge CKVD); #1;
            n++;
        end while (!m_acc_pulse && n < 300);
        chk("accept_timeout", 32'(m_acc_pulse), 32'd1);
    endtask

    task automatic send_cfg(input int nint, input int frac);
        CFG_NINT = 7'(nint);
        CFG_FRAC = 16'(frac);
        CFG_VLD = 1'b1;
        wait_accept();
        CFG_VLD = 1'b0;
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!LOCKED && n < 300) begin
            @(negedge CKVD);
            n++;
        end
        chk("lock_timeout", 32'(LOCKED), 32'd1);
    endtask

    initial begin
        int sum;
        int n;
        chk("pin_carry_4000_k3", 32'(carry_of(3, 16'h4000)), 32'd1);
        chk("pin_carry_4000_k2", 32'(carry_of(2, 16'h4000)), 32'd0);
        #22 NARST = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge CKVD);
            chk("idle_divnum", 32'(DIVNUM), 32'd32);
            chk("idle_rdy", 32'(CFG_RDY), 32'd1);
            chk("idle_locked", 32'(LOCKED), 32'd0);
        end

        // Ramp 32 -> 40, settle length, constant lock
        send_cfg(40, 0);
        chk("r40_accept_edge", 32'(DIVNUM), 32'd32);
        chk("r40_busy", 32'(BUSY), 32'd1);
        @(posedge CKVD); #1 chk("r40_step1", 32'(DIVNUM), 32'd36);
        @(posedge CKVD); #1 chk("r40_step2", 32'(DIVNUM), 32'd40);
        n = 0;
        while (!LOCKED && n < 50) begin
            @(posedge CKVD); #1;
            n++;
        end
        chk("settle_len", 32'(n), 32'd8);
        repeat (10) @(negedge CKVD);
        chk("r40_lock_divnum", 32'(DIVNUM), 32'd40);

        // Fractional quarter
        send_cfg(20, 16'h4000);
        wait_lock();
        @(negedge CKVD);
        sum = 0;
        for (int i = 0; i < 1024; i++) begin
            sum += int'(DIVNUM);
            @(negedge CKVD);
        end
        chk("frac_sum_1024", 32'(sum), 32'(1024 * 20 + 256));

        // Clamps
        send_cfg(2, 0);
        wait_lock();
        chk("clamp_low", 32'(DIVNUM), 32'd4);
        send_cfg(127, 16'hFFFF);
        wait_lock();
        repeat (2) @(negedge CKVD);
        chk("clamp_high_dither", 32'(DIVNUM), 32'd127);
        repeat (100) @(negedge CKVD);

        // Request held during ramp is only taken in LOCK
        send_cfg(60, 0);
        chk("r60_start", 32'(DIVNUM), 32'd126);
        CFG_NINT = 7'd10;
        CFG_FRAC = 16'h0;
        CFG_VLD = 1'b1;
        @(negedge CKVD);
        chk("held_rdy_low", 32'(CFG_RDY), 32'd0);
        chk("held_busy", 32'(BUSY), 32'd1);
        wait_accept();
        CFG_VLD = 1'b0;
        chk("r10_from_cur", 32'(DIVNUM), 32'd60);
        @(posedge CKVD); #1 chk("r10_step1", 32'(DIVNUM), 32'd56);
        wait_lock();
        chk("r10_lock", 32'(DIVNUM), 32'd10);

        // Random ratios, sometimes offered mid-ramp
        for (int it = 0; it < 25; it++) begin
            send_cfg(int'($urandom_range(0, 127)), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 40)) @(posedge CKVD);
            #1;
        end
        wait_lock();

        // Asynchronous reset mid-ramp
        send_cfg(36, 0);
        wait_lock();
        send_cfg(60, 0);
        chk("pre_rst_cur", 32'(DIVNUM), 32'd36);
        #2 NARST = 1'b0;
        #1;
        chk("arst_divnum", 32'(DIVNUM), 32'd32);
        chk("arst_rdy", 32'(CFG_RDY), 32'd1);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_locked", 32'(LOCKED), 32'd0);
        #20 NARST = 1'b1;
        repeat (3) @(negedge CKVD);
        chk("post_rst_divnum", 32'(DIVNUM), 32'd32);
        chk("post_rst_rdy", 32'(CFG_RDY), 32'd1);
        send_cfg(50, 16'h8000);
        wait_lock();
        repeat (20) @(negedge CKVD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
